fp_sqrte_sm: RTL and testbench

Sequenced square-root estimate unit for the nvio floating-point path. Computes sqrt(a) as a × rsqrt(a), the reverse application of the magic-constant reciprocal-square-root estimate. It forms y0 = 0x5F3759DF − (a32 >> 1), refines y0 with one Newton-Raphson step, then multiplies the result by a. One 32-bit multiplier pair and one adder/subtractor are time-shared by a state machine, with fixed latency, and the unit sits beside the reciprocal-square-root estimator in the fpUnit.

---
 rtl/fp_sqrte_sm_if.sv | 22 ++
 rtl/fp_sqrte_sm.sv | 239 +++++++++++++++++++++++
 tb/tb_fp_sqrte_sm.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_sqrte_sm_if.sv
// Bus between the square-root estimate unit and its host in the fpUnit.
//
// Handshake: the host drives ld for one cycle with the operand on a; the
// unit samples it on any clock edge where ld=1 and ce=1 and restarts, even
// if it is mid-operation. Results leave with done, a one-enabled-cycle
// pulse; o stays put from done until the next accepted result. busy is high
// from the cycle after an accepted ld through the done cycle. There is no
// back-pressure: the host must take o when done is high.
interface fp_sqrte_sm_if #(
  parameter int FPWID = 80
);
  logic             ce;
  logic             ld;
  logic [FPWID-1:0] a;
  logic [FPWID-1:0] o;
  logic             done;
  logic             busy;
  logic [3:0]       dbg_state;

  modport master (output ce, ld, a, input o, done, busy, dbg_state);
  modport slave  (input ce, ld, a, output o, done, busy, dbg_state);
endinterface

// File: rtl/fp_sqrte_sm.sv
// Sequenced square-root estimate: sqrt(a) = a * rsqrt(a), with rsqrt from
// the 0x5F3759DF magic constant plus one Newton step (two when the macro
// FPSQRTE_NR2_EN is defined). Two fp32 multipliers and one subtractor are
// shared across states; each state holds for STEP_CYCLES enabled cycles so
// the combinational arithmetic has a multicycle window to settle.
// Only FPWID=80 is meaningful (extended <-> single conversion).
module fp_sqrte_sm #(
  parameter int FPWID       = 80,
  parameter int STEP_CYCLES = 7
) (
  input logic          clk,
  input logic          rst_n,
  fp_sqrte_sm_if.slave bus
);

  localparam int CW = ($clog2(STEP_CYCLES) < 1) ? 1 : $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(STEP_CYCLES - 1);
  localparam logic [31:0] MAGIC = 32'h5F37_59DF;
  localparam logic [31:0] HALF  = 32'h3F00_0000;
  localparam logic [30:0] ONEP5 = 31'h3FC0_0000;
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;
  localparam logic [31:0] PINF  = 32'h7F80_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_MULP5, S_MULX2YY, S_SUB, S_MULY,
    S_MULYY2, S_MULX2YY2, S_SUB2, S_MULY2, S_MULA
  } state_t;

  typedef enum logic [2:0] {C_NORM, C_ZERO, C_NEG, C_INF, C_NAN} cls_t;

  // fp32 multiply, truncating; zero/denormal operands and underflow give zero
  function automatic logic [31:0] fmul32(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    logic [47:0] p;
    logic signed [9:0] e;
    logic [22:0] f;
    s = x[31] ^ y[31];
    p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    e = $signed({2'b0, x[30:23]}) + $signed({2'b0, y[30:23]}) - 10'sd127;
    if (p[47]) begin
      f = p[46:24];
      e = e + 10'sd1;
    end else begin
      f = p[45:23];
    end
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0 || e <= 10'sd0) fmul32 = {s, 31'b0};
    else if (e >= 10'sd255) fmul32 = {s, 8'hFF, 23'b0};
    else fmul32 = {s, e[7:0], f};
  endfunction

  // fp32 x - y for non-negative magnitudes (the only use is 1.5 - t, t >= 0)
  function automatic logic [31:0] fsub32(input logic [30:0] x, input logic [30:0] y);
    logic        swap, found;
    logic [30:0] big, sml;
    logic [7:0]  d;
    logic [25:0] mb, ms, diff, nrm;
    logic [4:0]  lz;
    logic signed [9:0] e;
    swap = (y > x);
    big  = swap ? y : x;
    sml  = swap ? x : y;
    d    = big[30:23] - sml[30:23];
    mb   = {1'b1, big[22:0], 2'b00};
    ms   = (d > 8'd25) ? 26'd0 : ({1'b1, sml[22:0], 2'b00} >> d);
    diff = mb - ms;
    lz = '0;
    found = 1'b0;
    for (int i = 25; i >= 0; i--) begin
      if (!found) begin
        if (diff[i]) found = 1'b1;
        else lz = lz + 5'd1;
      end
    end
    nrm = diff << lz;
    e = $signed({2'b0, big[30:23]}) - $signed({5'b0, lz});
    if (sml[30:23] == 8'd0) fsub32 = {swap, big};
    else if (diff == 26'd0 || e <= 10'sd0) fsub32 = {swap, 31'b0};
    else fsub32 = {swap, e[7:0], nrm[24:2]};
  endfunction

  // extended -> single; NaNs come out quiet, out-of-range small values as zero
  function automatic logic [31:0] f80_to_f32(input logic [79:0] x);
    logic        s;
    logic [14:0] ex;
    logic [63:0] m;
    logic signed [17:0] e;
    s  = x[79];
    ex = x[78:64];
    m  = x[63:0];
    e  = $signed({3'b0, ex}) - 18'sd16256;
    if (ex == 15'h7FFF) f80_to_f32 = (m[62:0] == 63'd0) ? {s, 8'hFF, 23'b0} : {s, 8'hFF, 1'b1, m[61:40]};
    else if (ex == 15'd0 || !m[63] || e <= 18'sd0) f80_to_f32 = {s, 31'b0};
    else if (e >= 18'sd255) f80_to_f32 = {s, 8'hFF, 23'b0};
    else f80_to_f32 = {s, e[7:0], m[62:40]};
  endfunction

  function automatic logic [79:0] f32_to_f80(input logic [31:0] x);
    if (x[30:23] == 8'd0) f32_to_f80 = {x[31], 79'b0};
    else if (x[30:23] == 8'hFF) f32_to_f80 = {x[31], 15'h7FFF, 1'b1, x[22:0], 40'b0};
    else f32_to_f80 = {x[31], 15'(x[30:23]) + 15'd16256, 1'b1, x[22:0], 40'b0};
  endfunction

  function automatic cls_t classify(input logic [31:0] v);
    if (v[30:23] == 8'hFF && v[22:0] != 23'd0) classify = C_NAN;
    else if (v[30:23] == 8'd0) classify = C_ZERO;
    else if (v[31]) classify = C_NEG;
    else if (v[30:23] == 8'hFF) classify = C_INF;
    else classify = C_NORM;
  endfunction

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] a32_q, y0_q, x2_q, yy_q, u_q, y1_q;
  logic [30:0] t_q;
  cls_t        cls_q;
  logic [FPWID-1:0] o_q;
  logic        done_q;

  logic [31:0] a32_ld, m0a, m0b, m1a, m1b, p0, p1, dsub, res_s;
  logic        last, cap_x2, cap_yy, cap_t, cap_u, cap_y1, fin;

  assign a32_ld = f80_to_f32(bus.a);
  assign p0     = fmul32(m0a, m0b);
  assign p1     = fmul32(m1a, m1b);
  assign dsub   = fsub32(ONEP5, t_q);

  // state register and step counter; ce low freezes both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (bus.ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: ld always restarts; otherwise advance on the last count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.ld) begin
      state_d = S_MULP5;
      cnt_d   = RELOAD;
    end else if (state_q != S_IDLE) begin
      if (cnt_q == '0) begin
        cnt_d = RELOAD;
        case (state_q)
          S_MULP5:    state_d = S_MULX2YY;
          S_MULX2YY:  state_d = S_SUB;
          S_SUB:      state_d = S_MULY;
`ifdef FPSQRTE_NR2_EN
          S_MULY:     state_d = S_MULYY2;
`else
          S_MULY:     state_d = S_MULA;
`endif
          S_MULYY2:   state_d = S_MULX2YY2;
          S_MULX2YY2: state_d = S_SUB2;
          S_SUB2:     state_d = S_MULY2;
          S_MULY2:    state_d = S_MULA;
          default:    state_d = S_IDLE;
        endcase
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // outputs of the FSM: multiplier operand steering and capture strobes
  always_comb begin
    m0a = a32_q;
    m0b = HALF;
    m1a = y0_q;
    m1b = y0_q;
    cap_x2 = 1'b0;
    cap_yy = 1'b0;
    cap_t  = 1'b0;
    cap_u  = 1'b0;
    cap_y1 = 1'b0;
    fin    = 1'b0;
    last   = (state_q != S_IDLE) && (cnt_q == '0);
    case (state_q)
      S_MULP5: begin cap_x2 = last; cap_yy = last; end
      S_MULX2YY, S_MULX2YY2: begin m0a = x2_q; m0b = yy_q; cap_t = last; end
      S_SUB, S_SUB2: cap_u = last;
      S_MULY:  begin m0a = y0_q; m0b = u_q; cap_y1 = last; end
      S_MULY2: begin m0a = y1_q; m0b = u_q; cap_y1 = last; end
      S_MULYY2: begin m1a = y1_q; m1b = y1_q; cap_yy = last; end
      S_MULA:  begin m0a = a32_q; m0b = y1_q; fin = last; end
      default: ;
    endcase
  end

  // special operands override the arithmetic result at the final step
  always_comb begin
    case (cls_q)
      C_ZERO:  res_s = {a32_q[31], 31'b0};
      C_NEG:   res_s = QNAN;
      C_INF:   res_s = PINF;
      C_NAN:   res_s = a32_q | 32'h0040_0000;
      default: res_s = p0;
    endcase
  end

  // datapath registers; a completing result is kept even if ld restarts now
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a32_q  <= '0;
      y0_q   <= '0;
      x2_q   <= '0;
      yy_q   <= '0;
      t_q    <= '0;
      u_q    <= '0;
      y1_q   <= '0;
      cls_q  <= C_NORM;
      o_q    <= '0;
      done_q <= 1'b0;
    end else if (bus.ce) begin
      done_q <= fin;
      if (fin) o_q <= f32_to_f80(res_s);
      if (bus.ld) begin
        a32_q <= a32_ld;
        y0_q  <= MAGIC - {1'b0, a32_ld[31:1]};
        cls_q <= classify(a32_ld);
      end
      if (cap_x2) x2_q <= p0;
      if (cap_yy) yy_q <= p1;
      if (cap_t)  t_q  <= p0[30:0];
      if (cap_u)  u_q  <= dsub;
      if (cap_y1) y1_q <= p0;
    end
  end

  assign bus.o         = o_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != S_IDLE) || done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fp_sqrte_sm.sv
module tb_fp_sqrte_sm;

`ifdef FPSQRTE_NR2_EN
  localparam int  LAT   = 63;
  localparam real TOL2  = 5.0e-6;
`else
  localparam int  LAT   = 35;
  localparam real TOL2  = 0.0018;
`endif
  localparam real TOL = 0.0018;

  logic clk;
  logic rst_n;
  int   edge_cnt;
  int   tests;
  int   fails;
  int   done_seen;
  int   ld_edge;

  fp_sqrte_sm_if #(.FPWID(80)) bus ();

  fp_sqrte_sm #(.FPWID(80), .STEP_CYCLES(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [79:0] exp_q[$];
  real         ref_q[$];
  real         tol_q[$];
  bit          exact_q[$];
  int          edge_q[$];
  string       name_q[$];

  function automatic real f80_to_real(input logic [79:0] v);
    real m;
    int  e;
    m = 0.0;
    for (int i = 63; i >= 0; i--) m = m * 2.0 + (v[i] ? 1.0 : 0.0);
    if (v[78:64] == 15'd0) return 0.0;
    e = int'(v[78:64]) - 16383 - 63;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return v[79] ? -m : m;
  endfunction

  // monitor: compare each done against the head of the expected queue
  logic [79:0] m_exp;
  real         m_ref, m_tol, m_got, m_err;
  bit          m_exact;
  int          m_edge;
  string       m_name;
  always @(negedge clk) begin
    if (bus.done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: edge %0d o=%h, expected no done", edge_cnt, bus.o);
      end else begin
        m_exp = exp_q.pop_front();
        m_ref = ref_q.pop_front();
        m_tol = tol_q.pop_front();
        m_exact = exact_q.pop_front();
        m_edge = edge_q.pop_front();
        m_name = name_q.pop_front();
        tests++;
        if (edge_cnt != m_edge) begin
          fails++;
          $display("FAIL %s latency: done at edge %0d, expected edge %0d", m_name, edge_cnt, m_edge);
        end
        tests++;
        if (m_exact) begin
          if (bus.o !== m_exp) begin
            fails++;
            $display("FAIL %s value: got %h expected %h", m_name, bus.o, m_exp);
          end
        end else begin
          m_got = f80_to_real(bus.o);
          m_err = (m_got - m_ref) / m_ref;
          if (m_err < 0.0) m_err = -m_err;
          if (!(m_err <= m_tol)) begin
            fails++;
            $display("FAIL %s value: got %h (%g) expected %g within rel %g", m_name, bus.o, m_got, m_ref, m_tol);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic check1(input string nm, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_ld(input logic [79:0] av);
    @(negedge clk);
    bus.ld = 1'b1;
    bus.a  = av;
    @(posedge clk);
    #1;
    ld_edge = edge_cnt;
    bus.ld = 1'b0;
  endtask

  task automatic push(input string nm, input logic [79:0] expv, input real refv, input real tol,
                      input bit exact, input int at_edge);
    exp_q.push_back(expv);
    ref_q.push_back(refv);
    tol_q.push_back(tol);
    exact_q.push_back(exact);
    edge_q.push_back(at_edge);
    name_q.push_back(nm);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete(); ref_q.delete(); tol_q.delete();
      exact_q.delete(); edge_q.delete(); name_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic run_one(input string nm, input logic [79:0] av, input logic [79:0] expv,
                         input real refv, input real tol, input bit exact);
    do_ld(av);
    push(nm, expv, refv, tol, exact, ld_edge + LAT);
    drain();
  endtask

  // stimulus
  int bad;
  int snap;
  initial begin
    tests = 0;
    fails = 0;
    done_seen = 0;
    rst_n = 1'b0;
    bus.ce = 1'b1;
    bus.ld = 1'b0;
    bus.a  = '0;
    repeat (3) @(posedge clk);
    #2;
    check1("reset_o", bus.o, 80'h0);
    check1("reset_done", 80'(bus.done), 80'h0);
    check1("reset_busy", 80'(bus.busy), 80'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // a=4.0 with busy window
    do_ld(80'h4001_8000000000000000);
    push("sqrt4", '0, 2.0, TOL, 1'b0, ld_edge + LAT);
    bad = 0;
    for (int j = 0; j <= LAT + 1; j++) begin
      @(negedge clk);
      if (bus.busy !== (j <= LAT)) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL busy_window: %0d cycles wrong, expected busy for edges 0..%0d only", bad, LAT);
    end
    drain();

    run_one("sqrt2",    80'h4000_8000000000000000, '0, 1.41421356, TOL2, 1'b0);
    run_one("sqrt0p25", 80'h3FFD_8000000000000000, '0, 0.5, TOL, 1'b0);
    run_one("sqrt2p100",  80'h4063_8000000000000000, '0, 1125899906842624.0, TOL, 1'b0);
    run_one("sqrt2m100",  80'h3F9B_8000000000000000, '0, 8.881784197001252e-16, TOL, 1'b0);
    run_one("pzero",    80'h0000_0000000000000000, 80'h0000_0000000000000000, 0.0, 0.0, 1'b1);
    run_one("nzero",    80'h8000_0000000000000000, 80'h8000_0000000000000000, 0.0, 0.0, 1'b1);
    run_one("neg1",     80'hBFFF_8000000000000000, 80'h7FFF_C000000000000000, 0.0, 0.0, 1'b1);
    run_one("pinf",     80'h7FFF_8000000000000000, 80'h7FFF_8000000000000000, 0.0, 0.0, 1'b1);
    run_one("ninf",     80'hFFFF_8000000000000000, 80'h7FFF_C000000000000000, 0.0, 0.0, 1'b1);
    run_one("qnan",     80'h7FFF_C000000000000000, 80'h7FFF_C000000000000000, 0.0, 0.0, 1'b1);
    run_one("nan_pay",  80'h7FFF_E000000000000000, 80'h7FFF_E000000000000000, 0.0, 0.0, 1'b1);
    run_one("snan",     80'h7FFF_A000000000000000, 80'h7FFF_E000000000000000, 0.0, 0.0, 1'b1);
    run_one("tiny",     80'h3F00_8000000000000000, 80'h0000_0000000000000000, 0.0, 0.0, 1'b1);

    // abort: 9.0 restarted by 16.0 at edge 12
    do_ld(80'h4002_9000000000000000);
    repeat (11) @(posedge clk);
    do_ld(80'h4003_8000000000000000);
    push("abort16", '0, 4.0, TOL, 1'b0, ld_edge + LAT);
    drain();

    // ce low on edges 10..19 adds ten cycles
    do_ld(80'h4001_8000000000000000);
    push("ce_gap", '0, 2.0, TOL, 1'b0, ld_edge + LAT + 10);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.ce = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.ce = 1'b1;
    drain();

    // ld with ce low is ignored
    @(negedge clk);
    bus.ce = 1'b0;
    bus.ld = 1'b1;
    bus.a  = 80'h4001_8000000000000000;
    @(posedge clk);
    #1;
    bus.ld = 1'b0;
    @(negedge clk);
    bus.ce = 1'b1;
    repeat (3) @(negedge clk);
    check1("ld_ce_low_busy", 80'(bus.busy), 80'h0);

    // new ld on the same edge as done: both results delivered
    do_ld(80'h4001_8000000000000000);
    push("coinc_a", '0, 2.0, TOL, 1'b0, ld_edge + LAT);
    repeat (LAT - 1) @(posedge clk);
    do_ld(80'h3FFD_8000000000000000);
    push("coinc_b", '0, 0.5, TOL, 1'b0, ld_edge + LAT);
    drain();

    // async reset mid-operation
    do_ld(80'h4001_8000000000000000);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check1("rst_mid_o", bus.o, 80'h0);
    check1("rst_mid_busy", 80'(bus.busy), 80'h0);
    snap = done_seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    tests++;
    if (done_seen != snap) begin
      fails++;
      $display("FAIL rst_no_done: %0d done pulses after reset, expected 0", done_seen - snap);
    end
    run_one("after_rst", 80'h4001_8000000000000000, '0, 2.0, TOL, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
